// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs feeding two registered CDB lanes,
// served round-robin across sources and oldest-first within a source.
module cdb_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int FIFO_DEPTH  = 2,
    parameter int ROB_W       = 6,
    parameter int DATA_W      = 32,
    parameter int INVALID_TAG = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*ROB_W-1:0]  src_rob,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      cdb_valid,
    output logic [ROB_W-1:0]          cdb_rob,
    output logic [DATA_W-1:0]         cdb_data,
    output logic                      cdb_valid2,
    output logic [ROB_W-1:0]          cdb_rob2,
    output logic [DATA_W-1:0]         cdb_data2
);

    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]    FULL     = CW'(FIFO_DEPTH);
    localparam logic [ROB_W-1:0] IDLE_TAG = ROB_W'(INVALID_TAG);

    logic [ROB_W-1:0]  rob_mem  [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [NUM_SRC][FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr   [NUM_SRC];
    logic [PW-1:0]     rd_ptr   [NUM_SRC];
    logic [CW-1:0]     count    [NUM_SRC];

    logic [SW-1:0]      rr_ptr, rr_nxt, scan_idx, g0_idx, g1_idx;
    logic               g0_valid, g1_valid;
    logic [NUM_SRC-1:0] push, pop;

    function automatic logic [SW-1:0] wrap_src(input int v);
        return SW'(v % NUM_SRC);
    endfunction

    // Ready depends only on the registered count, never on this cycle's grant.
    always_comb begin
        src_ready = '0;
        push      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = !reset && (count[i] != FULL);
            push[i]      = src_valid[i] && (count[i] != FULL) && !flush;
        end
    end

    always_comb begin
        g0_valid = 1'b0;
        g1_valid = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        scan_idx = '0;
        pop      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = wrap_src(int'(rr_ptr) + k);
            if (count[scan_idx] != '0) begin
                if (!g0_valid) begin
                    g0_valid = 1'b1;
                    g0_idx   = scan_idx;
                end else if (!g1_valid) begin
                    g1_valid = 1'b1;
                    g1_idx   = scan_idx;
                end
            end
        end
        if (g0_valid) pop[g0_idx] = 1'b1;
        if (g1_valid) pop[g1_idx] = 1'b1;
        rr_nxt = rr_ptr;
        if (g1_valid)      rr_nxt = wrap_src(int'(g1_idx) + 1);
        else if (g0_valid) rr_nxt = wrap_src(int'(g0_idx) + 1);
    end

    // Payload storage needs no reset; validity is carried entirely by count.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                rob_mem[i][wr_ptr[i]]  <= src_rob[i*ROB_W +: ROB_W];
                data_mem[i][wr_ptr[i]] <= src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr     <= '0;
            cdb_valid  <= 1'b0;
            cdb_rob    <= IDLE_TAG;
            cdb_data   <= '0;
            cdb_valid2 <= 1'b0;
            cdb_rob2   <= IDLE_TAG;
            cdb_data2  <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr     <= '0;
            cdb_valid  <= 1'b0;
            cdb_rob    <= IDLE_TAG;
            cdb_data   <= '0;
            cdb_valid2 <= 1'b0;
            cdb_rob2   <= IDLE_TAG;
            cdb_data2  <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
            rr_ptr     <= rr_nxt;
            cdb_valid  <= g0_valid;
            cdb_rob    <= g0_valid ? rob_mem[g0_idx][rd_ptr[g0_idx]]  : IDLE_TAG;
            cdb_data   <= g0_valid ? data_mem[g0_idx][rd_ptr[g0_idx]] : '0;
            cdb_valid2 <= g1_valid;
            cdb_rob2   <= g1_valid ? rob_mem[g1_idx][rd_ptr[g1_idx]]  : IDLE_TAG;
            cdb_data2  <= g1_valid ? data_mem[g1_idx][rd_ptr[g1_idx]] : '0;
        end
    end

endmodule
